// File: rtl/ex_mem_wb_stage.sv
// MEM stage of the RV32I pipeline: EX/MEM and MEM/WB registers, byte/half/word data memory,
// and branch resolution feeding PCSrc back to fetch.
module ex_mem_wb_stage #(
  parameter int unsigned DMEM_AW   = 10,
  parameter              INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        STALL_MEM,
  input  logic        FLUSH_MEM,
  input  logic [31:0] ALU_OUT_EX,
  input  logic [31:0] REG_DATA2_EX_FINAL,
  input  logic [31:0] PC_Branch_EX,
  input  logic        ZERO_EX,
  input  logic [4:0]  RD_EX,
  input  logic [2:0]  FUNCT3_EX,
  input  logic        RegWrite_EX,
  input  logic        MemtoReg_EX,
  input  logic        MemRead_EX,
  input  logic        MemWrite_EX,
  input  logic        Branch_EX,
  output logic [31:0] ALU_OUT_MEM,
  output logic [4:0]  RD_MEM,
  output logic        RegWrite_MEM,
  output logic [31:0] PC_Branch_MEM,
  output logic        PCSrc_MEM,
  output logic [4:0]  RD_WB,
  output logic        RegWrite_WB,
  output logic [31:0] ALU_DATA_WB,
  output logic        MISALIGN_WB
);

  localparam int unsigned DEPTH = 1 << DMEM_AW;

  logic [31:0] mem [DEPTH];

  logic [31:0] rs2_mem;
  logic        zero_mem;
  logic [2:0]  funct3_mem;
  logic        memtoreg_mem;
  logic        memread_mem;
  logic        memwrite_mem;
  logic        branch_mem;

  logic [31:0] alu_out_wb;
  logic [31:0] read_data_wb;
  logic        memtoreg_wb;

  // Flush only kills the control bits; data fields are left as-is since nothing consumes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALU_OUT_MEM   <= '0;
      rs2_mem       <= '0;
      PC_Branch_MEM <= '0;
      zero_mem      <= 1'b0;
      RD_MEM        <= '0;
      funct3_mem    <= '0;
      RegWrite_MEM  <= 1'b0;
      memtoreg_mem  <= 1'b0;
      memread_mem   <= 1'b0;
      memwrite_mem  <= 1'b0;
      branch_mem    <= 1'b0;
    end else if (FLUSH_MEM) begin
      RegWrite_MEM  <= 1'b0;
      memread_mem   <= 1'b0;
      memwrite_mem  <= 1'b0;
      branch_mem    <= 1'b0;
    end else if (!STALL_MEM) begin
      ALU_OUT_MEM   <= ALU_OUT_EX;
      rs2_mem       <= REG_DATA2_EX_FINAL;
      PC_Branch_MEM <= PC_Branch_EX;
      zero_mem      <= ZERO_EX;
      RD_MEM        <= RD_EX;
      funct3_mem    <= FUNCT3_EX;
      RegWrite_MEM  <= RegWrite_EX;
      memtoreg_mem  <= MemtoReg_EX;
      memread_mem   <= MemRead_EX;
      memwrite_mem  <= MemWrite_EX;
      branch_mem    <= Branch_EX;
    end
  end

  logic [DMEM_AW-1:0] word_idx;
  logic [1:0]         byte_off;
  logic               misalign;
  logic [31:0]        rd_word;
  logic [7:0]         sel_byte;
  logic [15:0]        sel_half;
  logic [31:0]        load_data;
  logic [3:0]         byte_en;
  logic [31:0]        wr_data;
  logic               wr_en;

  always_comb begin
    word_idx = ALU_OUT_MEM[DMEM_AW+1:2];
    byte_off = ALU_OUT_MEM[1:0];
    misalign = (memread_mem | memwrite_mem) &
               (((funct3_mem[1:0] == 2'b01) & byte_off[0]) |
                ((funct3_mem[1:0] == 2'b10) & (byte_off != 2'b00)));
    rd_word  = mem[word_idx];
    sel_byte = rd_word[{byte_off, 3'b000} +: 8];
    sel_half = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

    load_data = '0;
    if (!misalign) begin
      case (funct3_mem)
        3'b000:  load_data = {{24{sel_byte[7]}}, sel_byte};
        3'b001:  load_data = {{16{sel_half[15]}}, sel_half};
        3'b010:  load_data = rd_word;
        3'b100:  load_data = {24'd0, sel_byte};
        3'b101:  load_data = {16'd0, sel_half};
        default: load_data = '0;
      endcase
    end

    byte_en = '0;
    wr_data = rs2_mem;
    case (funct3_mem)
      3'b000: begin
        byte_en = 4'b0001 << byte_off;
        wr_data = {4{rs2_mem[7:0]}};
      end
      3'b001: begin
        byte_en = byte_off[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{rs2_mem[15:0]}};
      end
      3'b010:  byte_en = '1;
      default: byte_en = '0;
    endcase
    wr_en = memwrite_mem & ~STALL_MEM & ~misalign;
  end

  // Write lands on the edge closing the store's MEM cycle, so a load right behind it reads new data.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_wb   <= '0;
      read_data_wb <= '0;
      RD_WB        <= '0;
      RegWrite_WB  <= 1'b0;
      memtoreg_wb  <= 1'b0;
      MISALIGN_WB  <= 1'b0;
    end else if (!STALL_MEM) begin
      alu_out_wb   <= ALU_OUT_MEM;
      read_data_wb <= load_data;
      RD_WB        <= RD_MEM;
      RegWrite_WB  <= RegWrite_MEM;
      memtoreg_wb  <= memtoreg_mem;
      MISALIGN_WB  <= misalign;
    end
  end

  always_comb begin
    ALU_DATA_WB = memtoreg_wb ? read_data_wb : alu_out_wb;
    case (funct3_mem)
      3'b000:  PCSrc_MEM = branch_mem & zero_mem;
      3'b001:  PCSrc_MEM = branch_mem & ~zero_mem;
      default: PCSrc_MEM = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ex_mem_wb_stage.sv
// Directed bench for ex_mem_wb_stage: byte-array memory model plus per-cycle output comparison,
// with literal spot checks on the key load/store/branch/stall results.
module tb_ex_mem_wb_stage;

  localparam int AW    = 10;
  localparam int BYTES = 4 << AW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, flush = 1'b0;
  logic [31:0] alu_ex = '0, rs2_ex = '0, pcb_ex = '0;
  logic        zero_ex = 1'b0;
  logic [4:0]  rd_ex = '0;
  logic [2:0]  f3_ex = '0;
  logic        rw_ex = 1'b0, m2r_ex = 1'b0, mr_ex = 1'b0, mw_ex = 1'b0, br_ex = 1'b0;

  logic [31:0] alu_out_mem, pc_branch_mem, alu_data_wb;
  logic [4:0]  rd_mem, rd_wb;
  logic        regwrite_mem, pcsrc_mem, regwrite_wb, misalign_wb;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_mem_wb_stage #(.DMEM_AW(AW), .INIT_FILE("")) dut (
    .clk(clk), .rst_n(rst_n), .STALL_MEM(stall), .FLUSH_MEM(flush),
    .ALU_OUT_EX(alu_ex), .REG_DATA2_EX_FINAL(rs2_ex), .PC_Branch_EX(pcb_ex),
    .ZERO_EX(zero_ex), .RD_EX(rd_ex), .FUNCT3_EX(f3_ex),
    .RegWrite_EX(rw_ex), .MemtoReg_EX(m2r_ex), .MemRead_EX(mr_ex),
    .MemWrite_EX(mw_ex), .Branch_EX(br_ex),
    .ALU_OUT_MEM(alu_out_mem), .RD_MEM(rd_mem), .RegWrite_MEM(regwrite_mem),
    .PC_Branch_MEM(pc_branch_mem), .PCSrc_MEM(pcsrc_mem), .RD_WB(rd_wb),
    .RegWrite_WB(regwrite_wb), .ALU_DATA_WB(alu_data_wb), .MISALIGN_WB(misalign_wb)
  );

  // Model: instruction currently in MEM and in WB; dc marks fields left undefined by a flush.
  typedef struct {
    logic [31:0] alu, rs2, pcb;
    logic        zero;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        rw, m2r, mr, mw, br, dc;
  } mem_s;

  typedef struct {
    logic [31:0] alu, rdata;
    logic [4:0]  rd;
    logic        rw, m2r, mis, dc;
  } wb_s;

  mem_s m = '{default: '0};
  wb_s  w = '{default: '0};
  logic [7:0] ref_mem [BYTES];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int          ba;
    logic        mis;
    logic [31:0] rv;
    if (!rst_n) begin
      m = '{default: '0};
      w = '{default: '0};
      return;
    end
    ba  = int'(m.alu & 32'(BYTES - 1));
    mis = (m.mr || m.mw) && ((m.f3[1:0] == 2'd1 && ba % 2 != 0) ||
                             (m.f3[1:0] == 2'd2 && ba % 4 != 0));
    case (m.f3)
      3'd0:    rv = {{24{ref_mem[ba][7]}}, ref_mem[ba]};
      3'd4:    rv = {24'd0, ref_mem[ba]};
      3'd1:    rv = {{16{ref_mem[(ba+1)%BYTES][7]}}, ref_mem[(ba+1)%BYTES], ref_mem[ba]};
      3'd5:    rv = {16'd0, ref_mem[(ba+1)%BYTES], ref_mem[ba]};
      3'd2:    rv = {ref_mem[(ba+3)%BYTES], ref_mem[(ba+2)%BYTES], ref_mem[(ba+1)%BYTES], ref_mem[ba]};
      default: rv = 32'd0;
    endcase
    if (mis) rv = 32'd0;
    if (m.mw && !stall && !mis) begin
      if (m.f3 <= 3'd2) ref_mem[ba] = m.rs2[7:0];
      if (m.f3 == 3'd1 || m.f3 == 3'd2) ref_mem[ba+1] = m.rs2[15:8];
      if (m.f3 == 3'd2) begin
        ref_mem[ba+2] = m.rs2[23:16];
        ref_mem[ba+3] = m.rs2[31:24];
      end
    end
    if (!stall)
      w = '{alu: m.alu, rdata: rv, rd: m.rd, rw: m.rw, m2r: m.m2r, mis: mis, dc: m.dc};
    if (flush) begin
      m.rw = 1'b0; m.mr = 1'b0; m.mw = 1'b0; m.br = 1'b0; m.dc = 1'b1;
    end else if (!stall) begin
      m = '{alu: alu_ex, rs2: rs2_ex, pcb: pcb_ex, zero: zero_ex, rd: rd_ex, f3: f3_ex,
            rw: rw_ex, m2r: m2r_ex, mr: mr_ex, mw: mw_ex, br: br_ex, dc: 1'b0};
    end
  endtask

  task automatic check_all();
    logic taken;
    taken = m.br && ((m.f3 == 3'd0 && m.zero) || (m.f3 == 3'd1 && !m.zero));
    if (!m.dc) begin
      chk("alu_out_mem", alu_out_mem, m.alu);
      chk("rd_mem", 32'(rd_mem), 32'(m.rd));
      chk("pc_branch_mem", pc_branch_mem, m.pcb);
    end
    chk("regwrite_mem", 32'(regwrite_mem), 32'(m.rw));
    chk("pcsrc_mem", 32'(pcsrc_mem), 32'(taken));
    if (!w.dc) begin
      chk("rd_wb", 32'(rd_wb), 32'(w.rd));
      chk("alu_data_wb", alu_data_wb, w.m2r ? w.rdata : w.alu);
    end
    chk("regwrite_wb", 32'(regwrite_wb), 32'(w.rw));
    chk("misalign_wb", 32'(misalign_wb), 32'(w.mis));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic m2r, input logic mr,
                       input logic mw, input logic br, input logic zero, input logic [31:0] pcb);
    f3_ex = f3; alu_ex = alu; rs2_ex = rs2; rd_ex = rd; rw_ex = rw; m2r_ex = m2r;
    mr_ex = mr; mw_ex = mw; br_ex = br; zero_ex = zero; pcb_ex = pcb;
  endtask

  task automatic nop();
    drive(3'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask
  task automatic alu_op(input logic [31:0] v, input logic [4:0] rd);
    drive(3'd0, v, 32'd0, rd, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask
  task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    drive(f3, a, d, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
  endtask
  task automatic load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd);
    drive(f3, a, 32'd0, rd, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask
  task automatic branch(input logic [2:0] f3, input logic zero, input logic [31:0] tgt);
    drive(f3, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, zero, tgt);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nop();
    tick(); tick();
    chk("rst_alu_data_wb", alu_data_wb, 32'd0);
    chk("rst_pcsrc", 32'(pcsrc_mem), 32'd0);
    rst_n = 1'b1;

    alu_op(32'h1234_5678, 5'd5); tick();
    alu_op(32'hCAFE_0000, 5'd6); tick();
    chk("alu_fwd_wb", alu_data_wb, 32'h1234_5678);
    chk("alu_rd_wb", 32'(rd_wb), 32'd5);

    store(3'd2, 32'h10, 32'hDEAD_BEEF); tick();
    load(3'd0, 32'h10, 5'd1); tick();
    load(3'd4, 32'h10, 5'd2); tick(); chk("lb", alu_data_wb, 32'hFFFF_FFEF);
    load(3'd1, 32'h10, 5'd3); tick(); chk("lbu", alu_data_wb, 32'h0000_00EF);
    load(3'd5, 32'h10, 5'd4); tick(); chk("lh", alu_data_wb, 32'hFFFF_BEEF);
    load(3'd2, 32'h10, 5'd5); tick(); chk("lhu", alu_data_wb, 32'h0000_BEEF);
    load(3'd4, 32'h13, 5'd6); tick(); chk("lw", alu_data_wb, 32'hDEAD_BEEF);
    load(3'd1, 32'h12, 5'd7); tick(); chk("lbu_hi", alu_data_wb, 32'h0000_00DE);
    nop(); tick(); chk("lh_hi", alu_data_wb, 32'hFFFF_DEAD);

    store(3'd0, 32'h12, 32'h0000_0055); tick();
    load(3'd2, 32'h10, 5'd8); tick();
    nop(); tick(); chk("sb_then_lw", alu_data_wb, 32'hDE55_BEEF);

    store(3'd2, 32'h04, 32'h1122_3344); tick();
    store(3'd2, 32'h06, 32'hAAAA_AAAA); tick();
    load(3'd1, 32'h03, 5'd9); tick(); chk("sw_mis_flag", 32'(misalign_wb), 32'd1);
    load(3'd2, 32'h04, 5'd10); tick();
    chk("lh_mis_flag", 32'(misalign_wb), 32'd1);
    chk("lh_mis_data", alu_data_wb, 32'd0);
    nop(); tick();
    chk("sw_mis_nowrite", alu_data_wb, 32'h1122_3344);
    chk("aligned_flag", 32'(misalign_wb), 32'd0);
    store(3'd1, 32'h06, 32'h0000_CAFE); tick();
    load(3'd2, 32'h04, 5'd11); tick();
    nop(); tick(); chk("sh_upper", alu_data_wb, 32'hCAFE_3344);

    store(3'd2, 32'h8000_1014, 32'h0BAD_F00D); tick();
    load(3'd2, 32'h14, 5'd12); tick();
    nop(); tick(); chk("addr_wrap", alu_data_wb, 32'h0BAD_F00D);

    branch(3'd0, 1'b1, 32'h400); tick();
    chk("beq_taken", 32'(pcsrc_mem), 32'd1);
    chk("beq_target", pc_branch_mem, 32'h400);
    nop(); tick(); chk("beq_one_cycle", 32'(pcsrc_mem), 32'd0);
    branch(3'd1, 1'b1, 32'h800); tick(); chk("bne_not_taken", 32'(pcsrc_mem), 32'd0);
    branch(3'd1, 1'b0, 32'h900); tick(); chk("bne_taken", 32'(pcsrc_mem), 32'd1);
    nop(); tick();

    store(3'd2, 32'h20, 32'h1111_1111); tick();
    store(3'd2, 32'h20, 32'hCAFE_BABE); tick();
    stall = 1'b1;
    load(3'd2, 32'h20, 5'd13);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_hold_addr", alu_out_mem, 32'h20);
    end
    stall = 1'b0;
    tick();
    nop(); tick(); chk("stall_single_write", alu_data_wb, 32'hCAFE_BABE);

    store(3'd2, 32'h24, 32'h1234_5678); tick();
    store(3'd2, 32'h24, 32'h0000_9999); tick();
    stall = 1'b1; flush = 1'b1;
    alu_op(32'h77, 5'd3); tick();
    chk("flush_stall_rw", 32'(regwrite_mem), 32'd0);
    stall = 1'b0; flush = 1'b0;
    load(3'd2, 32'h24, 5'd14); tick();
    nop(); tick(); chk("flush_stall_nowrite", alu_data_wb, 32'h1234_5678);
    alu_op(32'h99, 5'd4); tick();
    chk("pre_flush_rw", 32'(regwrite_mem), 32'd1);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("flush_rw_mem", 32'(regwrite_mem), 32'd0);
    chk("flush_rw_wb", 32'(regwrite_wb), 32'd1);

    store(3'd2, 32'h28, 32'h5A5A_5A5A); tick();
    store(3'd2, 32'h28, 32'hFFFF_FFFF); tick();
    #2 rst_n = 1'b0;
    #1;
    model_step();
    check_all();
    chk("rst_mid_pcb", pc_branch_mem, 32'd0);
    chk("rst_mid_data", alu_data_wb, 32'd0);
    nop(); tick();
    rst_n = 1'b1;
    load(3'd2, 32'h28, 5'd15); tick();
    nop(); tick(); chk("rst_store_dropped", alu_data_wb, 32'h5A5A_5A5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
